// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared types, constants and helpers for the I2S receive path.
//   SAMPLE_W        : width of one captured audio sample
//   AES_VALID_BIT   : position of the valid flag in the 32-bit sample word
//   AES_SAMPLE_LSB  : LSB position of the sample inside the 32-bit word
//   aud_chan_t      : channel tag carried on tid (CH_LEFT / CH_RIGHT)
//   rx_word_t       : what the receive FIFO stores per entry
//   pack_aes_sample : builds the 32-bit word the transmitter path consumes
package i2s_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int AES_VALID_BIT  = 28;
  localparam int AES_SAMPLE_LSB = 12;

  typedef logic [2:0] aud_chan_t;

  localparam aud_chan_t CH_LEFT  = 3'd0;
  localparam aud_chan_t CH_RIGHT = 3'd1;

  typedef struct packed {
    aud_chan_t             chan;
    logic [SAMPLE_W-1:0]   sample;
  } rx_word_t;

  function automatic logic [31:0] pack_aes_sample(input logic [SAMPLE_W-1:0] sample);
    logic [31:0] word;
    word                                = '0;
    word[AES_VALID_BIT]                 = 1'b1;
    word[AES_SAMPLE_LSB +: SAMPLE_W]    = sample;
    return word;
  endfunction

endpackage

// File: rtl/i2s_rx_to_axis_if.sv
// i2s_rx_to_axis_if
// AXI-Stream bundle for received audio samples.
//   tdata  : 32-bit AES-style sample word
//   tid    : channel (CH_LEFT / CH_RIGHT)
//   tvalid : word available
//   tready : consumer accepts the word
// Modports: master (source of samples), slave (consumer).
interface i2s_rx_to_axis_if
  import i2s_pkg::*;
();

  logic [31:0] tdata;
  aud_chan_t   tid;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tid, output tvalid, input tready);
  modport slave  (input tdata, input tid, input tvalid, output tready);

endinterface

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo
// Small synchronous first-word-fall-through FIFO.
//   aud_mclk, aud_mrst : clock and synchronous active-high reset
//   push, push_data    : write request; ignored while full
//   pop                : read request; ignored while empty
//   pop_data           : head entry, valid whenever empty is low
//   full, empty        : status flags derived from wrap-bit pointers
module i2s_rx_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             aud_mclk,
  input  logic             aud_mrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam logic [LOG_DEPTH:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [2**LOG_DEPTH];
  logic [LOG_DEPTH:0] wr_ptr;
  logic [LOG_DEPTH:0] rd_ptr;
  logic do_push;
  logic do_pop;

  // The extra top pointer bit tells a full FIFO apart from an empty one
  // when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr[LOG_DEPTH-1:0]];

  always_ff @(posedge aud_mclk) begin
    if (do_push) begin
      mem[wr_ptr[LOG_DEPTH-1:0]] <= push_data;
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_to_axis.sv
// i2s_rx_to_axis
// I2S slave receiver: oversamples the external bit clock, word select and
// data with aud_mclk, captures the first 16 MSB-first bits of each slot and
// queues completed samples for an AXI-Stream consumer.
//   aud_mclk, aud_mrst : only clock; synchronous active-high reset
//   sclk_in, lrclk_in  : external bit clock and word select (0 = left)
//   sdata_0_in         : serial data, one-bit I2S delay
//   m_axis_aud         : AXI-Stream master (tdata/tid/tvalid/tready)
//   overflow_o         : one-cycle pulse when a completed sample is dropped
//   drop_cnt_o         : saturating drop counter, only when the macro
//                        I2S_RX_DROP_CNT_EN is defined
module i2s_rx_to_axis
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOG_DEPTH   = 2
) (
  input  logic aud_mclk,
  input  logic aud_mrst,
  input  logic sclk_in,
  input  logic lrclk_in,
  input  logic sdata_0_in,
  i2s_rx_to_axis_if.master m_axis_aud,
  output logic overflow_o
`ifdef I2S_RX_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt_o
`endif
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lrclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic sclk_hist;
  logic sclk_s;
  logic lrclk_s;
  logic sdata_s;

  logic        ws_q;
  logic        ws_loaded_q;
  logic        aligned_q;
  logic [4:0]  cnt_q;
  logic [15:0] sr_q;
  logic        push_q;
  rx_word_t    push_word_q;

  logic        rise;
  logic        ws_change;
  logic        cnt_room;
  logic        slot_full;
  logic        emit;
  logic [15:0] shifted;
  logic [15:0] slot_sample;

  logic        fifo_full;
  logic        fifo_empty;
  rx_word_t    fifo_head;

  // Plain synchroniser chains; the extra sclk flop gives the edge history.
  always_ff @(posedge aud_mclk) begin
    sclk_sync[0]  <= sclk_in;
    lrclk_sync[0] <= lrclk_in;
    sdata_sync[0] <= sdata_0_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sclk_sync[i]  <= sclk_sync[i-1];
      lrclk_sync[i] <= lrclk_sync[i-1];
      sdata_sync[i] <= sdata_sync[i-1];
    end
    sclk_hist <= sclk_s;
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];

  // Edges are ignored until ws_q holds a real lrclk sample after reset.
  assign rise        = sclk_s && !sclk_hist && ws_loaded_q;
  assign ws_change   = lrclk_s ^ ws_q;
  assign shifted     = {sr_q[14:0], sdata_s};
  assign cnt_room    = (cnt_q < 5'd16);
  // cnt_q saturates at 16, so the appended total reaches 16 only from 15 or 16.
  assign slot_full   = (cnt_q >= 5'd15);
  assign slot_sample = (cnt_q == 5'd15) ? shifted : sr_q;
  assign emit        = rise && ws_change && slot_full && aligned_q;

  // Deserialiser: the bit that arrives with a word-select change still
  // belongs to the slot that is ending.
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      ws_q        <= 1'b0;
      ws_loaded_q <= 1'b0;
      aligned_q   <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      push_q <= emit;
      if (emit) begin
        push_word_q.chan   <= ws_q ? CH_RIGHT : CH_LEFT;
        push_word_q.sample <= slot_sample;
      end
      if (!ws_loaded_q) begin
        ws_q        <= lrclk_s;
        ws_loaded_q <= 1'b1;
      end else if (rise) begin
        if (ws_change) begin
          cnt_q     <= '0;
          ws_q      <= lrclk_s;
          aligned_q <= 1'b1;
        end else if (cnt_room) begin
          sr_q  <= shifted;
          cnt_q <= cnt_q + 5'd1;
        end
      end
    end
  end

  i2s_rx_fifo #(
    .WIDTH     ($bits(rx_word_t)),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .aud_mclk  (aud_mclk),
    .aud_mrst  (aud_mrst),
    .push      (push_q),
    .push_data (push_word_q),
    .pop       (m_axis_aud.tready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fullness is judged before any pop in the same cycle, so a push into a
  // full FIFO is dropped even while the consumer is draining it.
  assign overflow_o = push_q && fifo_full;

  // Outputs are forced to zero while empty so reset leaves the bus at zero.
  assign m_axis_aud.tvalid = !fifo_empty;
  assign m_axis_aud.tdata  = fifo_empty ? 32'h0 : pack_aes_sample(fifo_head.sample);
  assign m_axis_aud.tid    = fifo_empty ? CH_LEFT : fifo_head.chan;

`ifdef I2S_RX_DROP_CNT_EN
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      drop_cnt_o <= '0;
    end else if (overflow_o && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule
